// File: rtl/io_input_conditioner.sv
// io_input_conditioner: synchronises and debounces board switches and
// push-buttons. It keeps sticky press/release flags for the buttons and
// exposes everything through a four-word registered-read window.
module io_input_conditioner #(
  parameter int SW_W           = 32,
  parameter int BTN_W          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int DB_CYCLES      = 50000,
  parameter int DB_CNT_W       = 16,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SW_W-1:0]  i_io_sw,
  input  logic [BTN_W-1:0] i_io_btn,
  input  logic             i_sel,
  input  logic             i_we,
  input  logic [1:0]       i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  output logic             o_rvld,
  output logic [SW_W-1:0]  o_sw_db,
  output logic [BTN_W-1:0] o_btn_db,
  output logic [BTN_W-1:0] o_btn_press,
  output logic             o_irq
);

  // Last count value before a new level is accepted.
  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);
  localparam logic [DB_CNT_W-1:0] CNT_ONE = DB_CNT_W'(1);

  // Buttons are flipped to "1 = pressed" before they enter the synchroniser,
  // so every later stage works in logical polarity.
  logic [BTN_W-1:0] btn_logical;
  assign btn_logical = BTN_ACTIVE_LOW ? ~i_io_btn : i_io_btn;

  logic [SW_W-1:0]     sw_sync  [SYNC_STAGES];
  logic [BTN_W-1:0]    btn_sync [SYNC_STAGES];
  logic [SW_W-1:0]     sw_s;
  logic [BTN_W-1:0]    btn_s;
  logic [SW_W-1:0]     sw_db;
  logic [BTN_W-1:0]    btn_db;
  logic [DB_CNT_W-1:0] sw_cnt  [SW_W];
  logic [DB_CNT_W-1:0] btn_cnt [BTN_W];
  logic [SW_W-1:0]     sw_accept;
  logic [BTN_W-1:0]    btn_accept;
  logic [BTN_W-1:0]    btn_rise;
  logic [BTN_W-1:0]    btn_fall;
  logic [BTN_W-1:0]    press_flag;
  logic [BTN_W-1:0]    release_flag;
  logic [BTN_W-1:0]    press_pulse;
  logic [BTN_W-1:0]    clr_press;
  logic [BTN_W-1:0]    clr_release;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  // Plain flop chain per channel with no logic between stages.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sw_sync[k]  <= '0;
        btn_sync[k] <= '0;
      end
    end else begin
      sw_sync[0]  <= i_io_sw;
      btn_sync[0] <= btn_logical;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sw_sync[k]  <= sw_sync[k-1];
        btn_sync[k] <= btn_sync[k-1];
      end
    end
  end

  assign sw_s  = sw_sync[SYNC_STAGES-1];
  assign btn_s = btn_sync[SYNC_STAGES-1];

  // A channel accepts its new level once it has differed for DB_CYCLES edges.
  always_comb begin
    sw_accept  = '0;
    btn_accept = '0;
    for (int i = 0; i < SW_W; i++)
      sw_accept[i] = (sw_s[i] != sw_db[i]) && (sw_cnt[i] == DB_LAST);
    for (int i = 0; i < BTN_W; i++)
      btn_accept[i] = (btn_s[i] != btn_db[i]) && (btn_cnt[i] == DB_LAST);
  end

  assign btn_rise = btn_accept & btn_s;
  assign btn_fall = btn_accept & ~btn_s;

  // Switch debounce: any return to the accepted level restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_db <= '0;
      for (int i = 0; i < SW_W; i++) sw_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < SW_W; i++) begin
        if (sw_s[i] == sw_db[i]) begin
          sw_cnt[i] <= '0;
        end else if (sw_accept[i]) begin
          sw_db[i]  <= sw_s[i];
          sw_cnt[i] <= '0;
        end else begin
          sw_cnt[i] <= sw_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Button debounce: same rule as the switches, in logical polarity.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      btn_db <= '0;
      for (int i = 0; i < BTN_W; i++) btn_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < BTN_W; i++) begin
        if (btn_s[i] == btn_db[i]) begin
          btn_cnt[i] <= '0;
        end else if (btn_accept[i]) begin
          btn_db[i]  <= btn_s[i];
          btn_cnt[i] <= '0;
        end else begin
          btn_cnt[i] <= btn_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign clr_press   = (i_sel && i_we && i_addr == 2'd2) ? i_wdata[BTN_W-1:0] : '0;
  assign clr_release = (i_sel && i_we && i_addr == 2'd3) ? i_wdata[BTN_W-1:0] : '0;
  assign unused_wdata = ^i_wdata;

  // Sticky flags; a new event on the same edge as a clear keeps the bit set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      press_flag   <= '0;
      release_flag <= '0;
      press_pulse  <= '0;
    end else begin
      press_flag   <= (press_flag & ~clr_press) | btn_rise;
      release_flag <= (release_flag & ~clr_release) | btn_fall;
      press_pulse  <= btn_rise;
    end
  end

  // Read mux sees pre-edge register state; unused upper bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (i_addr)
      2'd0:    rd_mux[SW_W-1:0]  = sw_db;
      2'd1:    rd_mux[BTN_W-1:0] = btn_db;
      2'd2:    rd_mux[BTN_W-1:0] = press_flag;
      default: rd_mux[BTN_W-1:0] = release_flag;
    endcase
  end

  // Registered read port; data holds between reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rdata <= '0;
      o_rvld  <= 1'b0;
    end else begin
      o_rvld <= i_sel & ~i_we;
      if (i_sel && !i_we) o_rdata <= rd_mux;
    end
  end

  assign o_sw_db     = sw_db;
  assign o_btn_db    = btn_db;
  assign o_btn_press = press_pulse;
  assign o_irq       = |press_flag;

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
Parametrised input front-end for the board switches and push-buttons that feed the pipelined core's IO space. Each channel gets a multi-stage synchroniser and a per-channel debounce counter. Buttons also get sticky press/release flags, a one-cycle press pulse and an interrupt line. The core's load/store unit reads the block through a small registered-read register window.

Parameters:
SW_W, 32, number of switch channels (1..32)
BTN_W, 4, number of button channels (1..32)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DB_CYCLES, 50000, consecutive stable cycles required to accept a new level (>=1)
DB_CNT_W, 16, debounce counter width; must satisfy 2^DB_CNT_W > DB_CYCLES
BTN_ACTIVE_LOW, 1, 1 = raw button low means pressed; inversion is applied before the synchroniser

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_io_sw  in  SW_W  raw switch inputs (asynchronous)
i_io_btn  in  BTN_W  raw button inputs (asynchronous)
i_sel  in  1  register-window access strobe
i_we  in  1  1 = write, 0 = read (qualified by i_sel)
i_addr  in  2  word select: 0 SW_STATE, 1 BTN_STATE, 2 BTN_PRESS, 3 BTN_RELEASE
i_wdata  in  32  write data (W1C masks)
o_rdata  out  32  registered read data
o_rvld  out  1  read data valid, one-cycle pulse
o_sw_db  out  SW_W  debounced switch levels
o_btn_db  out  BTN_W  debounced logical button levels (1 = pressed)
o_btn_press  out  BTN_W  one-cycle pulse on each debounced press
o_irq  out  1  OR of all BTN_PRESS flags

Behaviour:
- Reset: while i_rst is high, every flop clears immediately, independent of i_clk. This covers synchroniser stages (logical 0, i.e. released/off), debounced levels, counters, press/release flags, o_rdata and o_rvld. After reset all outputs are 0. Reset mid-debounce discards the partial count.
- Synchroniser: SYNC_STAGES flops in series per channel. No logic between stages.
- Debounce, per channel, synced value s, accepted level d, counter c:
  - s == d: c <= 0.
  - s != d and c == DB_CYCLES-1: d <= s, c <= 0.
  - Otherwise: c <= c+1.
  - A glitch shorter than DB_CYCLES cycles at s never changes d.
- Latency: a clean raw change first sampled at edge 0 appears on o_*_db after edge SYNC_STAGES+DB_CYCLES-1, i.e. SYNC_STAGES+DB_CYCLES edges total.
- Press/release detection:
  - o_btn_press[i] is high for exactly the one cycle following a 0->1 update of d[i].
  - On that same edge, BTN_PRESS[i] is set.
  - On a 1->0 update of d[i], BTN_RELEASE[i] is set.
- Flags are sticky until cleared. A write with i_sel=1, i_we=1 to addr 2/3 clears the bits set in i_wdata[BTN_W-1:0].
  - Set and clear of the same bit on the same edge: set wins.
  - Writes to addr 0/1 are ignored.
- Reads: i_sel=1, i_we=0 at edge N gives o_rdata valid and o_rvld=1 after edge N, for one cycle.
  - o_rvld returns to 0 next cycle unless another read is issued.
  - o_rdata holds its value when no read is issued.
  - Read data reflects register state before edge N's updates; a flag set on edge N is not visible.
  - Bits above SW_W/BTN_W read 0.
  - Back-to-back reads are allowed, one per cycle.
- o_irq: combinational OR of BTN_PRESS flags; deasserts the cycle after the last flag is cleared.

Test Plan:
(Bench settings: SW_W=8, BTN_W=4, SYNC_STAGES=2, DB_CYCLES=4, BTN_ACTIVE_LOW=1.)
1. Reset: raw btn=4'hF, sw=8'h00, release i_rst → o_btn_db=0, o_sw_db=0, flags 0, o_irq=0, o_rvld=0.
2. Clean press: raw btn[0] 1→0 held → o_btn_db[0]=1 after 6 edges; o_btn_press[0] high exactly 1 cycle; o_irq=1; read addr 2 → o_rdata=32'h1 with o_rvld one cycle later.
3. Bounce: raw sw[3] toggles every 2 cycles for 20 cycles, then stays 1 → o_sw_db[3] stays 0 during bouncing and goes to 1 six edges after the last toggle.
4. W1C race: BTN_PRESS=4'b0001; write addr 2, wdata=1, on the same edge that btn[0] debounces pressed again → flag remains 1. Write again with no event → flag 0, o_irq=0 next cycle.
5. Release and reset mid-count: btn[2] pressed, then released → BTN_RELEASE=4'b0100. Assert i_rst 2 cycles into a new debounce with no clock edge → all state 0 immediately; the count restarts from 0 after reset.
6. Back-to-back reads: addr 0,1,2,3 on consecutive cycles with sw=8'hA5 → o_rvld high 4 cycles; o_rdata=32'hA5, BTN state, PRESS, RELEASE in order.
